vote_tally_n: RTL and testbench

Parametrised N-voter ballot controller, the next generation of the fixed 9-voter board top. It runs a ballot session with a state machine (idle, open, count, result), synchronises and freezes voter switches, and tallies them serially. It compares the tally against a configurable pass threshold and drives the LED bank and a 4-digit multiplexed 7-segment display (agree / disagree counts). It sits directly under the board top, replacing the combinational vote/display/clear trio.

---
 rtl/vote_tally_n.sv | 166 ++++++++++++++++
 tb/tb_vote_tally_n.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vote_tally_n.sv
// Parametrised N-voter ballot controller: session FSM, serial tally, LED bank and 4-digit scanned display.
// Optional build macro VOTE_LOCK_EN makes registered agreement sticky while the ballot is open.
module vote_tally_n #(
  parameter int unsigned N_VOTERS = 9,
  parameter int unsigned THRESH   = 5,
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [N_VOTERS-1:0]               vote,
  input  logic                              start,
  input  logic                              close,
  input  logic                              clear,
  output logic [N_VOTERS-1:0]               ld_vote,
  output logic                              ld_pass,
  output logic                              ld_busy,
  output logic                              result_valid,
  output logic [$clog2(N_VOTERS+1)-1:0]     agree_cnt,
  output logic [3:0]                        seg_light,
  output logic [7:0]                        seg
);

  localparam int unsigned CW = $clog2(N_VOTERS + 1);
  localparam int unsigned DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_OPEN   = 2'd1,
    S_COUNT  = 2'd2,
    S_RESULT = 2'd3
  } state_t;

  state_t              state, state_nxt;
  logic [N_VOTERS-1:0] vote_m, vote_s, ballot;
  logic [CW-1:0]       acc, idx, disagree;
  logic [DW-1:0]       div, div_nxt;
  logic [1:0]          slot, slot_nxt;
  logic                vote_bit;
  logic [6:0]          agree7, dis7;
  logic [3:0]          digit, light_sel, light_nxt;
  logic                blank;
  logic [7:0]          seg_nxt;

  function automatic logic [7:0] seg_font(input logic [3:0] d);
    case (d)
      4'd0:    seg_font = 8'h3F;
      4'd1:    seg_font = 8'h06;
      4'd2:    seg_font = 8'h5B;
      4'd3:    seg_font = 8'h4F;
      4'd4:    seg_font = 8'h66;
      4'd5:    seg_font = 8'h6D;
      4'd6:    seg_font = 8'h7D;
      4'd7:    seg_font = 8'h07;
      4'd8:    seg_font = 8'h7F;
      4'd9:    seg_font = 8'h6F;
      default: seg_font = 8'h00;
    endcase
  endfunction

  // Session sequencing; clear overrides everything
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (start) state_nxt = S_OPEN;
        S_OPEN:   if (close) state_nxt = S_COUNT;
        S_COUNT:  if (idx == CW'(N_VOTERS)) state_nxt = S_RESULT;
        default:  state_nxt = state;
      endcase
    end
  end

  // Free-running digit scan: slot 0..3 drives digit 3..0
  always_comb begin
    div_nxt  = div + DW'(1);
    slot_nxt = slot;
    if (div == DW'(SCAN_DIV - 1)) begin
      div_nxt  = '0;
      slot_nxt = slot + 2'd1;
    end
  end

  assign vote_bit = |(ballot & (N_VOTERS'(1) << idx));
  assign disagree = CW'(N_VOTERS) - acc;
  assign agree7   = 7'(acc);
  assign dis7     = 7'(disagree);

  // Next display pattern, evaluated against the state being entered
  always_comb begin
    light_sel = 4'b1111;
    digit     = 4'd0;
    blank     = 1'b0;
    case (slot_nxt)
      2'd0: begin light_sel = 4'b0111; digit = 4'(agree7 / 7'd10); blank = (digit == 4'd0); end
      2'd1: begin light_sel = 4'b1011; digit = 4'(agree7 % 7'd10); end
      2'd2: begin light_sel = 4'b1101; digit = 4'(dis7 / 7'd10);   blank = (digit == 4'd0); end
      default: begin light_sel = 4'b1110; digit = 4'(dis7 % 7'd10); end
    endcase
    light_nxt = light_sel;
    seg_nxt   = 8'h40;
    case (state_nxt)
      S_IDLE: begin
        light_nxt = 4'b1111;
        seg_nxt   = 8'h00;
      end
      S_RESULT: seg_nxt = blank ? 8'h00 : seg_font(digit);
      default:  seg_nxt = 8'h40;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= S_IDLE;
      vote_m       <= '0;
      vote_s       <= '0;
      ballot       <= '0;
      acc          <= '0;
      idx          <= '0;
      div          <= '0;
      slot         <= '0;
      ld_pass      <= 1'b0;
      ld_busy      <= 1'b0;
      result_valid <= 1'b0;
      agree_cnt    <= '0;
      seg_light    <= 4'b1111;
      seg          <= 8'h00;
    end else begin
      state  <= state_nxt;
      vote_m <= vote;
      vote_s <= vote_m;
      div    <= div_nxt;
      slot   <= slot_nxt;

      // Ballot tracks the synchronised switches only while the session stays open
      if (state_nxt == S_IDLE) begin
        ballot <= '0;
      end else if (state == S_OPEN && state_nxt == S_OPEN) begin
`ifdef VOTE_LOCK_EN
        ballot <= ballot | vote_s;
`else
        ballot <= vote_s;
`endif
      end

      if (state_nxt == S_IDLE || (state_nxt == S_COUNT && state != S_COUNT)) begin
        acc <= '0;
        idx <= '0;
      end else if (state == S_COUNT && idx != CW'(N_VOTERS)) begin
        acc <= acc + CW'(vote_bit);
        idx <= idx + CW'(1);
      end

      ld_busy      <= (state_nxt == S_OPEN) || (state_nxt == S_COUNT);
      result_valid <= (state_nxt == S_RESULT);
      ld_pass      <= (state_nxt == S_RESULT) && (acc >= CW'(THRESH));
      agree_cnt    <= (state_nxt == S_RESULT) ? acc : '0;
      seg_light    <= light_nxt;
      seg          <= seg_nxt;
    end
  end

  assign ld_vote = ballot;

endmodule

// File: tb/tb_vote_tally_n.sv
// Directed bench for vote_tally_n: a 9-voter instance and a 20-voter fast-scan instance.
module tb_vote_tally_n;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [8:0]  vote = '0;
  logic        start = 1'b0, close = 1'b0, clear = 1'b0;
  logic [8:0]  ld_vote;
  logic        ld_pass, ld_busy, result_valid;
  logic [3:0]  agree_cnt;
  logic [3:0]  seg_light;
  logic [7:0]  seg;

  logic [19:0] vote_w = '0;
  logic        start_w = 1'b0, close_w = 1'b0, clear_w = 1'b0;
  logic [19:0] ld_vote_w;
  logic        ld_pass_w, ld_busy_w, rv_w;
  logic [4:0]  agree_w;
  logic [3:0]  seg_light_w;
  logic [7:0]  seg_w;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef VOTE_LOCK_EN
  localparam int LOCK_EXP = 1;
`else
  localparam int LOCK_EXP = 0;
`endif

  always #5 clk = ~clk;

  vote_tally_n #(.N_VOTERS(9), .THRESH(5), .SCAN_DIV(4)) u_dut (
    .clk(clk), .rst(rst), .vote(vote), .start(start), .close(close), .clear(clear),
    .ld_vote(ld_vote), .ld_pass(ld_pass), .ld_busy(ld_busy), .result_valid(result_valid),
    .agree_cnt(agree_cnt), .seg_light(seg_light), .seg(seg)
  );

  vote_tally_n #(.N_VOTERS(20), .THRESH(11), .SCAN_DIV(2)) u_wide (
    .clk(clk), .rst(rst), .vote(vote_w), .start(start_w), .close(close_w), .clear(clear_w),
    .ld_vote(ld_vote_w), .ld_pass(ld_pass_w), .ld_busy(ld_busy_w), .result_valid(rv_w),
    .agree_cnt(agree_w), .seg_light(seg_light_w), .seg(seg_w)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Settle the switches in IDLE, open a session and let the ballot catch up
  task automatic open_session(input logic [8:0] v);
    vote = v;
    ticks(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    ticks(4);
  endtask

  task automatic close_session();
    close = 1'b1;
    tick();
    close = 1'b0;
  endtask

  task automatic wait_rv(output int n);
    n = 0;
    while (!result_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  function automatic logic [3:0] next_light(input logic [3:0] l);
    case (l)
      4'b0111: next_light = 4'b1011;
      4'b1011: next_light = 4'b1101;
      4'b1101: next_light = 4'b1110;
      4'b1110: next_light = 4'b0111;
      default: next_light = 4'b0000;
    endcase
  endfunction

  initial begin
    int n;
    int bad;
    int run;
    int trans;
    logic [3:0] prev;
    logic [7:0] d3, d2, d1, d0;

    // Reset values
    tick();
    check("rst_ld_vote", 32'(ld_vote), 32'h0);
    check("rst_busy", 32'(ld_busy), 32'h0);
    check("rst_rv", 32'(result_valid), 32'h0);
    check("rst_seg_light", 32'(seg_light), 32'hF);
    check("rst_seg", 32'(seg), 32'h0);
    rst = 1'b0;
    ticks(2);

    // Pass vote: 5 of 9
    vote = 9'b000011111;
    ticks(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("open_busy", 32'(ld_busy), 32'h1);
    check("open_dash", 32'(seg), 32'h40);
    ticks(4);
    check("open_ld_vote", 32'(ld_vote), 32'h01F);
    close_session();
    wait_rv(n);
    check("rv_latency", 32'(n), 32'd10);
    check("pass_agree", 32'(agree_cnt), 32'd5);
    check("pass_ld_pass", 32'(ld_pass), 32'h1);
    check("pass_busy", 32'(ld_busy), 32'h0);
    d3 = 8'hFF; d2 = 8'hFF; d1 = 8'hFF; d0 = 8'hFF; bad = 0;
    for (int i = 0; i < 16; i++) begin
      case (seg_light)
        4'b0111: d3 = seg;
        4'b1011: d2 = seg;
        4'b1101: d1 = seg;
        4'b1110: d0 = seg;
        default: bad++;
      endcase
      tick();
    end
    check("pass_scan_onehot", 32'(bad), 32'd0);
    check("pass_agree_tens", 32'(d3), 32'h00);
    check("pass_agree_ones", 32'(d2), 32'h6D);
    check("pass_dis_tens", 32'(d1), 32'h00);
    check("pass_dis_ones", 32'(d0), 32'h66);

    do_clear();
    check("clr_rv", 32'(result_valid), 32'h0);
    check("clr_seg_light", 32'(seg_light), 32'hF);
    check("clr_seg", 32'(seg), 32'h0);
    check("clr_agree", 32'(agree_cnt), 32'h0);
    check("clr_ld_vote", 32'(ld_vote), 32'h0);

    // Fail vote, ballot frozen at close
    open_session(9'b000001111);
    close_session();
    vote = 9'h1FF;
    wait_rv(n);
    check("fail_latency", 32'(n), 32'd10);
    check("fail_agree", 32'(agree_cnt), 32'd4);
    check("fail_ld_pass", 32'(ld_pass), 32'h0);
    check("fail_frozen", 32'(ld_vote), 32'h00F);
    do_clear();

    // Priority: clear beats start and close
    vote = '0;
    start = 1'b1; clear = 1'b1;
    tick();
    start = 1'b0; clear = 1'b0;
    check("prio_start_busy", 32'(ld_busy), 32'h0);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("prio_open_busy", 32'(ld_busy), 32'h1);
    close = 1'b1; clear = 1'b1;
    tick();
    close = 1'b0; clear = 1'b0;
    check("prio_close_busy", 32'(ld_busy), 32'h0);
    check("prio_close_light", 32'(seg_light), 32'hF);
    ticks(12);
    check("prio_no_result", 32'(result_valid), 32'h0);

    // Retraction before close
    open_session(9'b000000001);
    vote = '0;
    ticks(4);
    close_session();
    wait_rv(n);
    check("lock_agree", 32'(agree_cnt), 32'(LOCK_EXP));
    do_clear();

    // Async reset while counting
    open_session(9'h1FF);
    close_session();
    ticks(4);
    check("cnt_busy", 32'(ld_busy), 32'h1);
    rst = 1'b1;
    #1;
    check("midrst_busy", 32'(ld_busy), 32'h0);
    check("midrst_ld_vote", 32'(ld_vote), 32'h0);
    check("midrst_seg", 32'(seg), 32'h0);
    check("midrst_light", 32'(seg_light), 32'hF);
    tick();
    rst = 1'b0;
    tick();
    check("postrst_light", 32'(seg_light), 32'hF);
    check("postrst_busy", 32'(ld_busy), 32'h0);
    ticks(15);
    check("postrst_no_result", 32'(result_valid), 32'h0);

    // Wide instance: 20 of 20
    vote_w = 20'hFFFFF;
    ticks(3);
    start_w = 1'b1;
    tick();
    start_w = 1'b0;
    ticks(4);
    close_w = 1'b1;
    tick();
    close_w = 1'b0;
    n = 0;
    while (!rv_w && n < 60) begin
      tick();
      n++;
    end
    check("wide_latency", 32'(n), 32'd21);
    check("wide_agree", 32'(agree_w), 32'd20);
    check("wide_pass", 32'(ld_pass_w), 32'h1);
    d3 = 8'hFF; d2 = 8'hFF; d1 = 8'hFF; d0 = 8'hFF;
    bad = 0; run = 1; trans = 0; prev = seg_light_w;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) begin
        if (seg_light_w == prev) run++;
        else begin
          if (trans > 0 && run != 2) bad++;
          if (seg_light_w != next_light(prev)) bad++;
          trans++;
          run = 1;
        end
      end
      case (seg_light_w)
        4'b0111: d3 = seg_w;
        4'b1011: d2 = seg_w;
        4'b1101: d1 = seg_w;
        4'b1110: d0 = seg_w;
        default: bad++;
      endcase
      prev = seg_light_w;
      tick();
    end
    check("wide_scan_order", 32'(bad), 32'd0);
    check("wide_scan_trans", 32'(trans >= 6), 32'h1);
    check("wide_agree_tens", 32'(d3), 32'h5B);
    check("wide_agree_ones", 32'(d2), 32'h3F);
    check("wide_dis_tens", 32'(d1), 32'h00);
    check("wide_dis_ones", 32'(d0), 32'h3F);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
